btn_ctrl: RTL

BTN_CTRL -- requirements
Module: btn_ctrl

---
 rtl/btn_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/btn_ctrl.sv
// btn_ctrl: N_CH-channel button synchroniser and debouncer with rise/fall
// pending registers, per-channel interrupt mask and a registered irq line.
module btn_ctrl #(
    parameter int unsigned N_CH       = 5,
    parameter int unsigned DEB_CYCLES = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic [N_CH-1:0] button,
    output logic            irq
);

    localparam int unsigned   CW       = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_STATE = 2'd0,
        REG_RISE  = 2'd1,
        REG_MASK  = 2'd2,
        REG_FALL  = 2'd3
    } reg_sel_e;

    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [N_CH-1:0] r_stable;
    logic [CW-1:0]   r_cnt [N_CH];
    logic [N_CH-1:0] r_rise_pend;
    logic [N_CH-1:0] r_fall_pend;
    logic [N_CH-1:0] r_mask;
    logic            r_irq;

    reg_sel_e        w_sel;
    logic [N_CH-1:0] w_stable_nxt;
    logic [CW-1:0]   w_cnt_nxt [N_CH];
    logic [N_CH-1:0] w_rise_set;
    logic [N_CH-1:0] w_fall_set;
    logic [N_CH-1:0] w_rise_clr;
    logic [N_CH-1:0] w_fall_clr;
    logic            w_mask_wr;
    logic            w_unused;

    assign w_sel    = reg_sel_e'(addr[3:2]);
    assign w_unused = ^{addr[31:4], addr[1:0], wdata};

    // Counter saturates at DEB_CYCLES-1; the level is accepted on the next mismatch.
    always_comb begin
        w_stable_nxt = r_stable;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_stable_nxt[i] = r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_rise_set = w_stable_nxt & ~r_stable;
    assign w_fall_set = r_stable & ~w_stable_nxt;
    assign w_mask_wr  = we && (w_sel == REG_MASK);
    assign w_rise_clr = (we && (w_sel == REG_RISE)) ? wdata[N_CH-1:0] : '0;
    assign w_fall_clr = (we && (w_sel == REG_FALL)) ? wdata[N_CH-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1  <= button;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_nxt;
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // A set on the same edge as a W1C wins; irq samples the registered pend/mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise_pend <= '0;
            r_fall_pend <= '0;
            r_mask      <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_rise_pend <= (r_rise_pend & ~w_rise_clr) | w_rise_set;
            r_fall_pend <= (r_fall_pend & ~w_fall_clr) | w_fall_set;
            if (w_mask_wr) begin
                r_mask <= wdata[N_CH-1:0];
            end
            r_irq <= |((r_rise_pend | r_fall_pend) & r_mask);
        end
    end

    assign irq = r_irq;

    always_comb begin
        rdata = '0;
        case (w_sel)
            REG_STATE: rdata[N_CH-1:0] = r_stable;
            REG_RISE:  rdata[N_CH-1:0] = r_rise_pend;
            REG_MASK:  rdata[N_CH-1:0] = r_mask;
            REG_FALL:  rdata[N_CH-1:0] = r_fall_pend;
            default:   rdata = '0;
        endcase
    end

endmodule
